mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Unified instruction/data memory slave answering the multicycle controller's fetch, load and store requests.
- Sits between the datapath's address mux (IorD) and the instruction/data registers.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns read data or a write acknowledge on a one-cycle response pulse.
- Lets the controller stall in FETCH/memory states until rsp_valid.

Parameters:
- ADDR_W, 32: byte-address width.
- DATA_W, 32: word width.
- DEPTH_WORDS, 64: number of stored words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 1: wait states between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = store, 0 = load/fetch.
- req_addr  in  ADDR_W  byte address; word index = req_addr[ADDR_W-1:2].
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  responder can accept this cycle.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads.
- rsp_err  out  1  request failed, valid with rsp_valid.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0.
  - Memory array contents are NOT cleared by reset.
- Handshake: a request is accepted on a clk edge where req_valid && req_ready.
  - On acceptance, req_write, word index and wdata are latched; later changes on req_* are ignored until the next acceptance.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On acceptance, go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise go straight to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle. When counter==0, go to RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly this cycle, then return to IDLE.
    - The memory access (read into rsp_rdata or write into array) is performed on the edge entering RESP.
- Latency: rsp_valid is high WAIT_CYCLES+1 cycles after the acceptance edge. Throughput is one request per WAIT_CYCLES+2 cycles.
- No back-to-back acceptance: req_ready returns high the cycle after RESP.
- Reads: rsp_rdata holds the addressed word and keeps that value after RESP until the next read response. Writes leave rsp_rdata unchanged.
- Out of range (word index >= DEPTH_WORDS): rsp_err=1, no array write, rsp_rdata=0.
- rsp_err is 0 on all other responses and falls with rsp_valid.
- Same-address read after write: the read returns the newly written word.
- Reset mid-operation (WAIT or RESP): return immediately to IDLE; a pending store is discarded and no rsp_valid is produced.
- req_valid while busy: ignored (req_ready=0); the requester must hold it.

Optional Feature:
- MEM_MISALIGN_CHECK_EN
  - Defined: a request with req_addr[1:0]!=0 completes with rsp_err=1, no array write, and rsp_rdata=0. Timing is the same as a normal access.
  - Undefined: req_addr[1:0] is ignored and the access targets the containing word.

Decomposition:
- Package mem_pkg holds:
  - state encoding localparams IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - wait-counter width WAIT_W=4;
  - helper constant WORD_OFF=2.
- One sub-module, mem_array_sp: single-port synchronous word array (DEPTH_WORDS x DATA_W) with we, word index, wdata and registered rdata.
- mem_responder holds the FSM, counter, latches and error logic.

Test Plan:
- Reset then idle: assert rst for 3 cycles, then release -> req_ready=1, rsp_valid=0, rsp_rdata=0 throughout 5 idle cycles.
- Write/read, WAIT_CYCLES=1:
  - Store 0xDEADBEEF to addr 0x10 -> rsp_valid exactly 2 cycles after acceptance, rsp_err=0.
  - Then load addr 0x10 -> rsp_rdata=0xDEADBEEF.
- Zero wait, WAIT_CYCLES=0: load addr 0x0 after preloading 0x12345678 -> rsp_valid 1 cycle after acceptance; req_ready low for exactly 1 cycle.
- Out of range, DEPTH_WORDS=64:
  - Store 0xAAAA5555 to addr 0x100 -> rsp_err=1.
  - Subsequent load of addr 0x0 returns the unchanged prior value; load of 0x100 returns rsp_err=1, rsp_rdata=0.
- Reset mid-op, WAIT_CYCLES=3: accept store 0x1 to addr 0x4, assert rst during WAIT -> no rsp_valid; after release, load addr 0x4 returns the pre-store value.
- Misalign: load addr 0x6 -> with MEM_MISALIGN_CHECK_EN, rsp_err=1; without it, rsp_rdata equals the word at 0x4, rsp_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the unified instruction/data memory responder.
package mem_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Wait-state counter width (WAIT_CYCLES up to 15)
    localparam int WAIT_W = 4;

    // Byte-offset bits below the word index
    localparam int WORD_OFF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_WAIT = WAIT,
        ST_RESP = RESP
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_if: request/response handshake between the multicycle controller and memory.
interface mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_array_sp.sv
// mem_array_sp: single-port synchronous word array with a registered read port.
// Contents are not reset; only the read register is.
module mem_array_sp #(
    parameter int DEPTH_WORDS = 64,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    // Read register; holds its value between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory slave for the multicycle controller. Accepts one request,
// waits WAIT_CYCLES states, then pulses rsp_valid for one cycle.
// Optional: `define MEM_MISALIGN_CHECK_EN to fail accesses with req_addr[1:0] != 0.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input logic  clk,
    input logic  rst,
    mem_if.slave bus
);
    localparam int IDX_W  = ADDR_W - WORD_OFF;
    localparam int AIDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state, state_nx;
    logic [WAIT_W-1:0] cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              accept, enter_resp;
    logic              acc_write, acc_err, acc_oor;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              rd_zero, rsp_err_q;
    logic [DATA_W-1:0] arr_rdata;

    assign accept = bus.req_valid && (state == ST_IDLE);

    // FSM next state and handshake outputs
    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: if (cnt == '0) state_nx = ST_RESP;
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                state_nx      = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Wait-state counter, loaded on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                cnt <= '0;
        else if (accept)                        cnt <= CNT_INIT;
        else if (state == ST_WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end

    // Request latch; req_* is free to change once accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

    // The access happens on the edge into RESP. With zero wait states that is the
    // acceptance edge itself, so the live request is used while still in IDLE.
    assign enter_resp = (state_nx == ST_RESP);
    assign acc_write  = (state == ST_IDLE) ? bus.req_write : lat_write;
    assign acc_addr   = (state == ST_IDLE) ? bus.req_addr  : lat_addr;
    assign acc_wdata  = (state == ST_IDLE) ? bus.req_wdata : lat_wdata;
    assign acc_oor    = acc_addr[ADDR_W-1:WORD_OFF] >= IDX_W'(DEPTH_WORDS);

`ifdef MEM_MISALIGN_CHECK_EN
    assign acc_err = acc_oor || (acc_addr[WORD_OFF-1:0] != '0);
`else
    logic unused_lo;
    assign unused_lo = ^acc_addr[WORD_OFF-1:0];
    assign acc_err   = acc_oor;
`endif

    mem_array_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (AIDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (enter_resp && acc_write && !acc_err),
        .re    (enter_resp && !acc_write && !acc_err),
        .idx   (acc_addr[WORD_OFF +: AIDX_W]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    // Read-data mask (failed reads return zero) and error flag aligned with RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_zero   <= 1'b1;
            rsp_err_q <= 1'b0;
        end else begin
            if (enter_resp && !acc_write) rd_zero <= acc_err;
            rsp_err_q <= enter_resp && acc_err;
        end
    end

    assign bus.rsp_rdata = rd_zero ? '0 : arr_rdata;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (WAIT_CYCLES 1, 0, 3) checked against a word-array
// model with directed steps followed by random traffic.
module tb_mem_responder;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        vld = '0;
    logic              wr = 1'b0;
    logic [31:0]       addr = '0, wd = '0;
    logic [2:0]        rdy, rv, er;
    logic [2:0][31:0]  rd;

    int n_cmp = 0, n_err = 0;
    logic [31:0] model [3][64];
    logic [31:0] last  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        assign bus.req_valid = vld[g];
        assign bus.req_write = wr;
        assign bus.req_addr  = addr;
        assign bus.req_wdata = wd;
        assign rdy[g] = bus.req_ready;
        assign rv[g]  = bus.rsp_valid;
        assign rd[g]  = bus.rsp_rdata;
        assign er[g]  = bus.rsp_err;
        mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(WC)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int wc(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on responder k; called and returns at a negedge with k idle.
    task automatic txn(input int k, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
        bit          e;
        int          lat;
        logic [31:0] exp_rd;
        e = (a >> 2) >= 64;
`ifdef MEM_MISALIGN_CHECK_EN
        if (a[1:0] != 2'b00) e = 1'b1;
`endif
        if (w) begin
            if (!e) model[k][a[7:2]] = d;
            exp_rd = last[k];
        end else begin
            exp_rd  = e ? 32'h0 : model[k][a[7:2]];
            last[k] = exp_rd;
        end
        check({tag, " ready_before"}, {31'b0, rdy[k]}, 32'd1);
        vld[k] = 1'b1; wr = w; addr = a; wd = d;
        @(posedge clk);
        @(negedge clk);
        vld[k] = 1'b0; wr = 1'($urandom); addr = $urandom; wd = $urandom;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            if (rv[k] === 1'b1) begin
                lat = n;
                break;
            end
            check({tag, " busy_ready"}, {31'b0, rdy[k]}, 32'd0);
            @(negedge clk);
        end
        check({tag, " latency"}, lat, wc(k) + 1);
        check({tag, " ready_in_resp"}, {31'b0, rdy[k]}, 32'd0);
        check({tag, " err"}, {31'b0, er[k]}, {31'b0, e});
        check({tag, " rdata"}, rd[k], exp_rd);
        @(negedge clk);
        check({tag, " valid_drop"}, {31'b0, rv[k]}, 32'd0);
        check({tag, " err_drop"}, {31'b0, er[k]}, 32'd0);
        check({tag, " ready_back"}, {31'b0, rdy[k]}, 32'd1);
        check({tag, " rdata_hold"}, rd[k], exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) last[k] = 32'h0;

        // Reset, then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 3; k++) begin
                check("idle ready", {31'b0, rdy[k]}, 32'd1);
                check("idle valid", {31'b0, rv[k]}, 32'd0);
                check("idle rdata", rd[k], 32'h0);
            end
            @(negedge clk);
        end

        // Fill every word so later reads compare against known data
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 64; i++)
                txn(k, 1'b1, 32'(i * 4), $urandom, "preload");

        // Write/read, one wait state
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, "w1 store");
        txn(0, 1'b0, 32'h10, 32'h0, "w1 load");

        // Zero wait states
        txn(1, 1'b1, 32'h0, 32'h12345678, "w0 preload");
        txn(1, 1'b0, 32'h0, 32'h0, "w0 load");

        // Out of range: no aliasing write into word 0
        txn(0, 1'b1, 32'h100, 32'hAAAA5555, "oor store");
        txn(0, 1'b0, 32'h0, 32'h0, "oor word0");
        txn(0, 1'b0, 32'h100, 32'h0, "oor load");
        txn(0, 1'b0, 32'h8000_0010, 32'h0, "oor high");
        txn(0, 1'b0, 32'hFC, 32'h0, "last word");

        // Misaligned load
        txn(0, 1'b0, 32'h6, 32'h0, "misalign load");
        txn(1, 1'b1, 32'h9, 32'h0BAD_F00D, "misalign store");
        txn(1, 1'b0, 32'h8, 32'h0, "misalign check");

        // Reset during WAIT discards the pending store
        check("midrst ready_before", {31'b0, rdy[2]}, 32'd1);
        vld[2] = 1'b1; wr = 1'b1; addr = 32'h4; wd = 32'h1;
        @(posedge clk);
        @(negedge clk);
        vld[2] = 1'b0;
        check("midrst in_wait ready", {31'b0, rdy[2]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst valid_in_rst", {29'b0, rv}, 32'd0);
        check("midrst ready_in_rst", {29'b0, rdy}, 32'd7);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) last[k] = 32'h0;
        for (int c = 0; c < 6; c++) begin
            check("midrst no_valid", {31'b0, rv[2]}, 32'd0);
            check("midrst rdata_zero", rd[2], 32'h0);
            @(negedge clk);
        end
        txn(2, 1'b0, 32'h4, 32'h0, "midrst load");

        // Random traffic, including out-of-range and misaligned addresses
        for (int t = 0; t < 90; t++) begin
            int          k;
            bit          w;
            logic [31:0] a;
            k = int'($urandom_range(0, 2));
            w = 1'($urandom);
            a = $urandom_range(0, 32'h11F);
            if (t % 15 == 0) a = $urandom;
            txn(k, w, a, $urandom, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
